// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline stall/flush control.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_e;

  // One bundle holds every stage-register enable and bubble-insert control.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // No event: every stage advances, no bubbles.
  localparam stage_ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Reset / error: nothing moves, nothing is flushed.
  localparam stage_ctrl_t CTRL_IDLE = '0;

  // Memory stall: front end frozen, WB gets a bubble so no register is written twice.
  localparam stage_ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1
  };

  // Load-use: hold PC and IF_ID, push a bubble into EX, back end keeps draining.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_flush: 1'b0
  };

  // Taken branch: PC takes the target, squash the two younger instructions.
  localparam stage_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: load in EX feeding a source of the ID instruction.
module hazard_detect (
  input  logic       memread,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       hazard
);

  // x0 is never a real dependency, so rd==0 cannot cause a stall.
  always_comb begin
    hazard = memread && (rd != 5'd0) &&
             ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait FSM with timeout,
// branch squash, load-use bubble and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EX_memread,
  input  logic [4:0]             ID_EX_rd,
  input  logic [4:0]             IF_ID_rs1,
  input  logic [4:0]             IF_ID_rs2,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic                   branch_taken_EX,
  input  logic                   mem_req_MEM,
  input  logic                   mem_ack,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_flush,
  output logic                   mem_busy,
  output logic                   bus_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  pipe_state_e     state;
  logic [WC_W-1:0] wait_cnt;
  stage_ctrl_t     ctrl;
  logic            load_use;
  logic            count_stall;

  hazard_detect u_hazard_detect (
    .memread  (ID_EX_memread),
    .rd       (ID_EX_rd),
    .rs1      (IF_ID_rs1),
    .rs2      (IF_ID_rs2),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .hazard   (load_use)
  );

  // Output mux: memory stall > branch > load-use > advance; idle in reset and ERR.
  always_comb begin
    ctrl        = CTRL_ADVANCE;
    count_stall = 1'b0;
    if (!rst_n) begin
      ctrl = CTRL_IDLE;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ack) begin
            ctrl        = CTRL_MEM_STALL;
            count_stall = 1'b1;
          end else if (branch_taken_EX) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl        = CTRL_LOAD_USE;
            count_stall = 1'b1;
          end
        end
        MEM_WAIT: begin
          // A branch held in EX during the wait is only acted on once ack releases it.
          if (!mem_ack) begin
            ctrl        = CTRL_MEM_STALL;
            count_stall = 1'b1;
          end else if (branch_taken_EX) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl        = CTRL_LOAD_USE;
            count_stall = 1'b1;
          end
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_busy     = rst_n && (state == MEM_WAIT);

  // Memory-wait FSM with timeout, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      bus_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (count_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_LAST) begin
            state   <= ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          bus_err <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ID_EX_memread;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic        branch_taken_EX;
  logic        mem_req_MEM;
  logic        mem_ack;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic        mem_busy;
  logic        bus_err;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
  localparam logic [7:0] V_OFF = 8'b00000_000;
  localparam logic [7:0] V_ADV = 8'b11111_000;
  localparam logic [7:0] V_MEM = 8'b00001_001;
  localparam logic [7:0] V_LU  = 8'b00111_010;
  localparam logic [7:0] V_BR  = 8'b11111_110;

  logic [7:0] ctrl_v;
  assign ctrl_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_EX_memread   (ID_EX_memread),
    .ID_EX_rd        (ID_EX_rd),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_rs2       (IF_ID_rs2),
    .rs1_used        (rs1_used),
    .rs2_used        (rs2_used),
    .branch_taken_EX (branch_taken_EX),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ack         (mem_ack),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
    .mem_busy        (mem_busy),
    .bus_err         (bus_err),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_EX_memread   = 1'b0;
    ID_EX_rd        = 5'd0;
    IF_ID_rs1       = 5'd0;
    IF_ID_rs2       = 5'd0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    branch_taken_EX = 1'b0;
    mem_req_MEM     = 1'b0;
    mem_ack         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    ID_EX_memread   = 1'($urandom);
    ID_EX_rd        = 5'($urandom);
    IF_ID_rs1       = 5'($urandom);
    IF_ID_rs2       = 5'($urandom);
    rs1_used        = 1'($urandom);
    rs2_used        = 1'($urandom);
    branch_taken_EX = 1'($urandom);
    mem_req_MEM     = 1'b1;
    mem_ack         = 1'($urandom);
    #1;
    total++;
    if (ctrl_v !== V_OFF) begin
      bad++; $display("FAIL reset_ctrl_pre: got %b want %b", ctrl_v, V_OFF);
    end
    tick();
    tick();
    total++;
    if (ctrl_v !== V_OFF) begin
      bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl_v, V_OFF);
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
    total++;
    if (bus_err !== 1'b0 || mem_busy !== 1'b0) begin
      bad++; $display("FAIL reset_err_busy: got err=%b busy=%b want 0 0", bus_err, mem_busy);
    end
    clear_inputs();
    rst_n = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_ADV) begin
      bad++; $display("FAIL reset_release_adv: got %b want %b", ctrl_v, V_ADV);
    end
    tick();
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    // rs2 match
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5; rs2_used = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_LU) begin
      bad++; $display("FAIL lu_rs2: got %b want %b", ctrl_v, V_LU);
    end
    tick(); exp_stall++;
    total++;
    if (stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL lu_rs2_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    // rs1 match
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd17; IF_ID_rs1 = 5'd17; rs1_used = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_LU) begin
      bad++; $display("FAIL lu_rs1: got %b want %b", ctrl_v, V_LU);
    end
    tick(); exp_stall++;
    // rd == x0 never stalls
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs2 = 5'd0; rs2_used = 1'b1;
    IF_ID_rs1 = 5'd0; rs1_used = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_ADV) begin
      bad++; $display("FAIL lu_rd0: got %b want %b", ctrl_v, V_ADV);
    end
    tick();
    // matching register but source unused
    clear_inputs();
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd9; IF_ID_rs2 = 5'd9; rs2_used = 1'b0;
    #1;
    total++;
    if (ctrl_v !== V_ADV) begin
      bad++; $display("FAIL lu_unused_src: got %b want %b", ctrl_v, V_ADV);
    end
    // match but not a load
    ID_EX_memread = 1'b0; rs2_used = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_ADV) begin
      bad++; $display("FAIL lu_not_load: got %b want %b", ctrl_v, V_ADV);
    end
    tick();
    total++;
    if (stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL lu_count_final: got %0d want %0d", stall_cycles, exp_stall);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req_MEM = 1'b1; mem_ack = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++;
      if (ctrl_v !== V_MEM) begin
        bad++; $display("FAIL memwait_stall_c%0d: got %b want %b", c, ctrl_v, V_MEM);
      end
      total++;
      if (mem_busy !== (c > 1)) begin
        bad++; $display("FAIL memwait_busy_c%0d: got %b want %b", c, mem_busy, (c > 1));
      end
      tick(); exp_stall++;
    end
    mem_ack = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_ADV || mem_busy !== 1'b1) begin
      bad++; $display("FAIL memwait_ack: got %b busy=%b want %b busy=1", ctrl_v, mem_busy, V_ADV);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (mem_busy !== 1'b0 || ctrl_v !== V_ADV) begin
      bad++; $display("FAIL memwait_back_run: got %b busy=%b want %b busy=0", ctrl_v, mem_busy, V_ADV);
    end
    total++;
    if (stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL memwait_count: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_zero_wait();
    mem_req_MEM = 1'b1; mem_ack = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_ADV || mem_busy !== 1'b0) begin
      bad++; $display("FAIL zerowait_ctrl: got %b busy=%b want %b busy=0", ctrl_v, mem_busy, V_ADV);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (mem_busy !== 1'b0 || stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL zerowait_state: got busy=%b cnt=%0d want busy=0 cnt=%0d",
                      mem_busy, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_priority();
    mem_req_MEM = 1'b1; mem_ack = 1'b0; branch_taken_EX = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      #1;
      total++;
      if (ctrl_v !== V_MEM) begin
        bad++; $display("FAIL prio_mem_over_br_c%0d: got %b want %b", c, ctrl_v, V_MEM);
      end
      tick(); exp_stall++;
    end
    mem_ack = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_BR) begin
      bad++; $display("FAIL prio_br_on_ack: got %b want %b", ctrl_v, V_BR);
    end
    tick();
    clear_inputs();
    // branch and load-use together
    branch_taken_EX = 1'b1;
    ID_EX_memread = 1'b1; ID_EX_rd = 5'd3; IF_ID_rs1 = 5'd3; rs1_used = 1'b1;
    #1;
    total++;
    if (ctrl_v !== V_BR) begin
      bad++; $display("FAIL prio_br_over_lu: got %b want %b", ctrl_v, V_BR);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL prio_count: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_timeout();
    mem_req_MEM = 1'b1; mem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      total++;
      if (ctrl_v !== V_MEM || bus_err !== 1'b0) begin
        bad++; $display("FAIL timeout_stall_c%0d: got %b err=%b want %b err=0", c, ctrl_v, bus_err, V_MEM);
      end
      tick(); exp_stall++;
    end
    #1;
    total++;
    if (bus_err !== 1'b1 || ctrl_v !== V_OFF || mem_busy !== 1'b0) begin
      bad++; $display("FAIL timeout_err: got err=%b ctrl=%b busy=%b want err=1 ctrl=%b busy=0",
                      bus_err, ctrl_v, mem_busy, V_OFF);
    end
    tick();
    total++;
    if (stall_cycles !== 32'(exp_stall)) begin
      bad++; $display("FAIL timeout_no_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    mem_ack = 1'b1;
    #1;
    total++;
    if (bus_err !== 1'b1 || ctrl_v !== V_OFF) begin
      bad++; $display("FAIL timeout_late_ack: got err=%b ctrl=%b want err=1 ctrl=%b", bus_err, ctrl_v, V_OFF);
    end
    tick();
    total++;
    if (bus_err !== 1'b1 || ctrl_v !== V_OFF) begin
      bad++; $display("FAIL timeout_sticky: got err=%b ctrl=%b want err=1 ctrl=%b", bus_err, ctrl_v, V_OFF);
    end
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_stall = 0;
    #1;
    total++;
    if (bus_err !== 1'b0 || stall_cycles !== 32'd0 || ctrl_v !== V_ADV) begin
      bad++; $display("FAIL timeout_reset_clear: got err=%b cnt=%0d ctrl=%b want err=0 cnt=0 ctrl=%b",
                      bus_err, stall_cycles, ctrl_v, V_ADV);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_zero_wait();
    test_priority();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
